// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// VGA timing generator and framebuffer scanout engine. A 160x120 framebuffer
// held in an external synchronous RAM is scanned out to a 640x480 display.
// Each framebuffer pixel covers a 4x4 block of display pixels.
//
// One clock domain. The pixel rate is half the system clock: an internal
// enable toggles every clk, and all counting and output updates happen on
// the clks where that enable is high.
//
// Ports
//   clk          in   1   system clock (50 MHz)
//   reset        in   1   synchronous, active-high reset
//   rd_addr      out  15  framebuffer read address, row*cols + col; 0 when blanked
//   rd_data      in   8   framebuffer pixel, valid 1 clk after rd_addr;
//                         [5:4]=R, [3:2]=G, [1:0]=B, [7:6] unused
//   frame_start  out  1   one-clk pulse after the counters wrap to (0,0)
//   VGA_CLK      out  1   pixel clock (25 MHz), rises mid-way through stable data
//   VGA_HS       out  1   horizontal sync, active-low
//   VGA_VS       out  1   vertical sync, active-low
//   VGA_BLANK_N  out  1   low outside the active region
//   VGA_SYNC_N   out  1   tied low
//   VGA_R/G/B    out  8   colour channels, 2-bit field replicated to 8 bits
// ---------------------------------------------------------------------------
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  // -------------------------------------------------------------------------
  // Derived geometry
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  // Framebuffer is a quarter of the display in each direction.
  localparam int FB_COLS = H_ACTIVE / 4;

  localparam logic [HC_W-1:0] HC_LAST       = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HC_ACTIVE     = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HC_SYNC_FIRST = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HC_SYNC_LAST  = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [VC_W-1:0] VC_LAST       = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VC_ACTIVE     = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VC_SYNC_FIRST = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VC_SYNC_LAST  = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [14:0] FB_STRIDE = 15'(FB_COLS);

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Replicate a 2-bit colour field across 8 bits so full scale maps to 8'hFF.
  function automatic logic [7:0] expand_channel(input logic [1:0] c);
    return {c, c, c, c};
  endfunction

  // Framebuffer address of the 4x4 block that contains display pixel (hc,vc).
  function automatic logic [14:0] fb_address(input logic [HC_W-1:0] hc,
                                             input logic [VC_W-1:0] vc);
    logic [14:0] row;
    logic [14:0] col;
    row = 15'(vc >> 2);
    col = 15'(hc >> 2);
    return (row * FB_STRIDE) + col;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic            pix_en_r;
  logic [HC_W-1:0] hc_r;
  logic [VC_W-1:0] vc_r;

  logic active_s;
  logic hsync_s;
  logic vsync_s;
  logic hc_last_s;
  logic vc_last_s;

  // Colour bits [7:6] of the framebuffer word carry nothing for this block.
  logic unused_rd_bits_s;
  assign unused_rd_bits_s = ^rd_data[7:6];

  assign VGA_SYNC_N = 1'b0;

  // Position decode from the current counters.
  always_comb begin
    active_s  = (hc_r < HC_ACTIVE) && (vc_r < VC_ACTIVE);
    hsync_s   = (hc_r >= HC_SYNC_FIRST) && (hc_r <= HC_SYNC_LAST);
    vsync_s   = (vc_r >= VC_SYNC_FIRST) && (vc_r <= VC_SYNC_LAST);
    hc_last_s = (hc_r == HC_LAST);
    vc_last_s = (vc_r == VC_LAST);
  end

  // Read address follows the counters directly; the RAM answers one clk
  // later, which lands in the pix_en=1 clk when the outputs capture it.
  always_comb begin
    rd_addr = 15'd0;
    if (active_s) begin
      rd_addr = fb_address(hc_r, vc_r);
    end else begin
      rd_addr = 15'd0;
    end
  end

  // Pixel enable and raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en_r <= 1'b0;
      hc_r     <= '0;
      vc_r     <= '0;
    end else begin
      pix_en_r <= ~pix_en_r;
      if (pix_en_r) begin
        if (hc_last_s) begin
          hc_r <= '0;
          if (vc_last_s) begin
            vc_r <= '0;
          end else begin
            vc_r <= vc_r + VC_W'(1);
          end
        end else begin
          hc_r <= hc_r + HC_W'(1);
        end
      end
    end
  end

  // Output registers: sync, blank and colour are captured together on the
  // pix_en=1 clk, so the video outputs trail the counters by one pixel period.
  // Reset drops any sync pulse in progress immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
    end else if (pix_en_r) begin
      VGA_HS      <= ~hsync_s;
      VGA_VS      <= ~vsync_s;
      VGA_BLANK_N <= active_s;
      if (active_s) begin
        VGA_R <= expand_channel(rd_data[5:4]);
        VGA_G <= expand_channel(rd_data[3:2]);
        VGA_B <= expand_channel(rd_data[1:0]);
      end else begin
        VGA_R <= 8'd0;
        VGA_G <= 8'd0;
        VGA_B <= 8'd0;
      end
    end else begin
      VGA_HS      <= VGA_HS;
      VGA_VS      <= VGA_VS;
      VGA_BLANK_N <= VGA_BLANK_N;
      VGA_R       <= VGA_R;
      VGA_G       <= VGA_G;
      VGA_B       <= VGA_B;
    end
  end

  // Pixel clock is low in the clk after an output update and high in the
  // next, placing its rising edge in the middle of each stable pixel.
  // frame_start marks the wrap from the last pixel of the frame to (0,0);
  // reset clears the counters without producing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_CLK     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      VGA_CLK     <= ~pix_en_r;
      frame_start <= pix_en_r & hc_last_s & vc_last_s;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
//
// Self-checking bench for vga_scanout. The DUT runs with a scaled-down raster
// geometry so that several complete frames fit in a short run; every expected
// value is derived from the same parameters.
//
// A reference raster model advances on the clock. On every pixel-enable clk
// it pushes the expected video word into a scoreboard queue; the monitor pops
// it half a clock later and compares it with the DUT outputs. A small RAM
// model answers rd_addr one clk later and drives junk on the clks where the
// DUT must not sample. Sync widths/periods, frame period and the active-pixel
// count per frame are measured directly from the DUT outputs.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

  localparam int H_ACTIVE = 32;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 16;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;

  localparam int H_TOT      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLKS = 2 * H_TOT * V_TOT;
  localparam int FB_W       = H_ACTIVE / 4;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vid_t;

  localparam vid_t RST_VID = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0,
                               r: 8'h00, g: 8'h00, b: 8'h00};

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rd_addr;
  logic [7:0]  rd_data;
  logic        frame_start;
  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  vga_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_start(frame_start),
    .VGA_CLK    (VGA_CLK),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N (VGA_SYNC_N),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_active(input int h, input int v);
    return (h < H_ACTIVE) && (v < V_ACTIVE);
  endfunction

  function automatic logic [14:0] exp_addr(input int h, input int v);
    if (is_active(h, v)) return 15'((v / 4) * FB_W + (h / 4));
    return 15'd0;
  endfunction

  function automatic vid_t expect_vid(input int h, input int v, input logic [7:0] d);
    vid_t e;
    e.hs      = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    e.vs      = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    e.blank_n = is_active(h, v);
    e.r       = e.blank_n ? 8'(d[5:4]) * 8'h55 : 8'h00;
    e.g       = e.blank_n ? 8'(d[3:2]) * 8'h55 : 8'h00;
    e.b       = e.blank_n ? 8'(d[1:0]) * 8'h55 : 8'h00;
    return e;
  endfunction

  // -------------------------------------------------------------------------
  // Reference raster model and scoreboard producer
  // -------------------------------------------------------------------------
  int          cyc = 0;
  int          ref_hc = 0;
  int          ref_vc = 0;
  logic        ref_pix = 1'b0;
  logic        ref_vclk = 1'b0;
  logic        ref_fs = 1'b0;
  logic        ref_rst_d = 1'b0;
  logic [7:0]  exp_data = 8'h00;
  int          data_mode = 1;
  logic [7:0]  const_data = 8'h3F;
  vid_t        sb_q[$];

  logic [14:0] ea_s;
  logic        act_s;

  always_comb begin
    ea_s  = exp_addr(ref_hc, ref_vc);
    act_s = is_active(ref_hc, ref_vc);
  end

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    ref_rst_d <= reset;
    if (reset) begin
      ref_pix  <= 1'b0;
      ref_hc   <= 0;
      ref_vc   <= 0;
      ref_vclk <= 1'b0;
      ref_fs   <= 1'b0;
    end else begin
      ref_pix  <= !ref_pix;
      ref_vclk <= !ref_pix;
      ref_fs   <= ref_pix && (ref_hc == H_TOT - 1) && (ref_vc == V_TOT - 1);
      if (ref_pix) begin
        sb_q.push_back(expect_vid(ref_hc, ref_vc, exp_data));
        if (ref_hc == H_TOT - 1) begin
          ref_hc <= 0;
          ref_vc <= (ref_vc == V_TOT - 1) ? 0 : ref_vc + 1;
        end else begin
          ref_hc <= ref_hc + 1;
        end
      end
    end
  end

  // RAM model: real data in the clk the DUT samples, junk otherwise.
  always @(posedge clk) begin
    if (ref_pix) begin
      rd_data <= 8'($urandom);
    end else begin
      case (data_mode)
        0: begin
          rd_data  <= rd_addr[7:0];
          exp_data <= ea_s[7:0];
        end
        1: begin
          rd_data  <= const_data;
          exp_data <= const_data;
        end
        default: begin
          rd_data  <= act_s ? 8'h24 : 8'hFF;
          exp_data <= act_s ? 8'h24 : 8'hFF;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: scoreboard consumer and timing measurements
  // -------------------------------------------------------------------------
  vid_t last_exp;
  vid_t got_vid;
  logic started = 1'b0;
  int   fs_ref_id = 0;
  int   act_cnt = 0;
  logic hs_prev, vs_prev;
  logic hs_ok, vs_ok, hs_fall_ok, vs_fall_ok, hs_first, vs_first;
  int   hs_run, vs_run, hs_fall_id, vs_fall_id;

  initial begin
    forever begin
      @(negedge clk);
      if (ref_rst_d) started = 1'b1;
      if (started) begin
        if (ref_rst_d) begin
          sb_q.delete();
          last_exp   = RST_VID;
          fs_ref_id  = cyc;
          act_cnt    = 0;
          hs_ok      = 1'b0;
          vs_ok      = 1'b0;
          hs_fall_ok = 1'b0;
          vs_fall_ok = 1'b0;
          hs_first   = 1'b1;
          vs_first   = 1'b1;
          hs_prev    = 1'b1;
          vs_prev    = 1'b1;
        end else if (sb_q.size() > 0) begin
          last_exp = sb_q.pop_front();
        end

        got_vid = '{hs: VGA_HS, vs: VGA_VS, blank_n: VGA_BLANK_N,
                    r: VGA_R, g: VGA_G, b: VGA_B};
        check_val("video", got_vid, last_exp);
        check_val("rd_addr", rd_addr, ea_s);
        check_val("vga_clk", VGA_CLK, ref_vclk);
        check_val("frame_start", frame_start, ref_fs);
        check_val("sync_n", VGA_SYNC_N, 1'b0);

        if (!VGA_CLK && VGA_BLANK_N) act_cnt++;

        if (frame_start) begin
          check_val("frame_period", cyc - fs_ref_id, FRAME_CLKS);
          check_val("active_px", act_cnt, H_ACTIVE * V_ACTIVE);
          fs_ref_id = cyc;
          act_cnt   = 0;
          hs_first  = 1'b1;
          vs_first  = 1'b1;
        end

        if (hs_prev && !VGA_HS) begin
          if (hs_fall_ok) check_val("hs_period", cyc - hs_fall_id, 2 * H_TOT);
          if (hs_first) check_val("hs_offset", cyc - fs_ref_id, 2 * (H_ACTIVE + H_FP) + 2);
          hs_first   = 1'b0;
          hs_fall_id = cyc;
          hs_fall_ok = 1'b1;
          hs_run     = 0;
          hs_ok      = 1'b1;
        end
        if (!VGA_HS) hs_run++;
        if (!hs_prev && VGA_HS && hs_ok) check_val("hs_width", hs_run, 2 * H_SYNC);
        hs_prev = VGA_HS;

        if (vs_prev && !VGA_VS) begin
          if (vs_fall_ok) check_val("vs_period", cyc - vs_fall_id, FRAME_CLKS);
          if (vs_first) check_val("vs_offset", cyc - fs_ref_id,
                                  2 * H_TOT * (V_ACTIVE + V_FP) + 2);
          vs_first   = 1'b0;
          vs_fall_id = cyc;
          vs_fall_ok = 1'b1;
          vs_run     = 0;
          vs_ok      = 1'b1;
        end
        if (!VGA_VS) vs_run++;
        if (!vs_prev && VGA_VS && vs_ok) check_val("vs_width", vs_run, 2 * V_SYNC * H_TOT);
        vs_prev = VGA_VS;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < FRAME_CLKS + 100) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, frame_start, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Clk after the first unreset edge: outputs still in reset state.
    @(negedge clk);
    check_val("pre_update_blank", VGA_BLANK_N, 1'b0);
    check_val("pre_update_vclk", VGA_CLK, 1'b1);
    // Second edge: first output update, white pixel from 8'h3F.
    @(negedge clk);
    check_val("first_blank", VGA_BLANK_N, 1'b1);
    check_val("first_r", VGA_R, 8'hFF);
    check_val("first_g", VGA_G, 8'hFF);
    check_val("first_b", VGA_B, 8'hFF);

    wait_fs("fs_const");
    data_mode = 0;
    wait_fs("fs_addr");
    data_mode = 2;
    wait_fs("fs_mixed");
    data_mode = 0;

    // Reset in the middle of both sync pulses.
    n = 0;
    while (!(ref_hc == H_ACTIVE + H_FP + 1 && ref_vc == V_ACTIVE + V_FP) &&
           n < FRAME_CLKS + 100) begin
      @(negedge clk);
      n++;
    end
    check_val("pre_rst_hs", VGA_HS, 1'b0);
    check_val("pre_rst_vs", VGA_VS, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_hs", VGA_HS, 1'b1);
    check_val("rst_vs", VGA_VS, 1'b1);
    check_val("rst_blank", VGA_BLANK_N, 1'b0);
    check_val("rst_addr", rd_addr, 15'd0);
    check_val("rst_fs", frame_start, 1'b0);

    wait_fs("fs_after_rst");
    for (int i = 0; i < 3; i++) wait_fs("fs_run");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameters SHALL be: H_ACTIVE 640; H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480; V_FP 10; V_SYNC 2; V_BP 33; all are counts of 640x480 display pixels/lines.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high; one clock domain only.
- rd_addr  out  15  framebuffer read address, (row*160 + col).
- rd_data  in  8  framebuffer pixel, valid 1 clk after rd_addr (synchronous RAM); [5:4]=R, [3:2]=G, [1:0]=B, [7:6] ignored.
- frame_start  out  1  one-clk pulse at the start of each frame.
- VGA_CLK  out  1  pixel clock, 25 MHz.
- VGA_HS  out  1  horizontal sync, active-low.
- VGA_VS  out  1  vertical sync, active-low.
- VGA_BLANK_N  out  1  low outside the active region.
- VGA_SYNC_N  out  1  constant 0.
- VGA_R, VGA_G, VGA_B  out  8 each  colour channels.

Function
REQ-003 Internal pix_en SHALL toggle every clk and be 0 in the first clk after reset release; one pixel period = 2 clks.
REQ-004 Counters hc (0..799) and vc (0..524) SHALL advance only on clks where pix_en=1.
- hc increments; 799 wraps to 0.
- vc increments only when hc wraps; 524 wraps to 0.
REQ-005 rd_addr SHALL be combinational from the current counters.
- Active region (hc<640 and vc<480): (vc>>2)*160 + (hc>>2), range 0..19199.
- Outside the active region: 0.
- Each 160x120 framebuffer pixel is therefore replicated into a 4x4 display block.
REQ-006 On each pix_en=1 clk, the output registers SHALL capture from the current counters and rd_data, so outputs lag the counters by exactly one pixel period.
- VGA_HS = 0 iff 656<=hc<=751.
- VGA_VS = 0 iff 490<=vc<=491.
- VGA_BLANK_N = 1 iff hc<640 and vc<480.
- Channel outputs = 2-bit field replicated four times ({c,c,c,c}, so 2'b11 gives 8'hFF and 2'b01 gives 8'h55) when active; 0 when blanked.
REQ-007 Output registers SHALL hold their values on pix_en=0 clks.
REQ-008 VGA_CLK SHALL be registered: 0 in the clk following an output-register update and 1 in the next clk, so its rising edge falls mid-way through stable data.
REQ-009 frame_start SHALL pulse high for exactly one clk, in the clk immediately after the counters wrap from (799,524) to (0,0).
- No pulse SHALL be generated when counters reach (0,0) via reset.
REQ-010 rd_data SHALL be sampled only at pix_en=1 clks; rd_data at pix_en=0 clks SHALL NOT affect outputs.
REQ-011 Line period SHALL be 1600 clks and frame period 840000 clks, exactly, with no drift.
REQ-012 The block SHALL have no input handshake; it reads continuously and has no stall condition.

Reset
REQ-013 While reset=1 at a clk edge, the following registers SHALL load their reset values.
- hc=0, vc=0, pix_en=0.
- VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0.
- VGA_R/G/B=0, VGA_CLK=0, frame_start=0.
- As a result, rd_addr=0.
REQ-014 Reset asserted mid-line or mid-frame SHALL abandon the current frame immediately, with no partial sync pulse extension.
- Counting SHALL resume from (0,0) with the first pix_en=1 clk, 2 clks after reset deasserts.

Verification
REQ-015 Reset, then run 1 frame with rd_data=8'h3F -> first output update occurs 2 clks after release with BLANK_N=1, R=G=B=8'hFF; 307200 active pixel periods per frame.
REQ-016 Measure sync timing -> HS low for 96 pixel periods (192 clks) every 1600 clks, starting 656 periods after line start; VS low for exactly 2 lines (3200 clks) every 840000 clks.
REQ-017 Address check with RAM model mem[a]=a[7:0] -> rd_addr=0 for hc 0..3 on vc 0..3; rd_addr=1 at hc=4; rd_addr=160 at vc=4, hc=0; rd_addr=19199 at (639,479); rd_addr=0 throughout blanking.
REQ-018 rd_data=8'h24 (R=2, G=1, B=0) -> R=8'hAA, G=8'h55, B=8'h00 while active; all channels 0 during blanking even with rd_data=8'hFF.
REQ-019 Assert reset for 1 clk at hc=700, vc=300 -> next clk: HS=1, VS=1, BLANK_N=0, rd_addr=0; no frame_start pulse; the following frame_start arrives exactly 840000 clks after counting resumes.
REQ-020 Run 3 frames -> exactly one frame_start per 840000 clks, each 1 clk wide; VGA_CLK has period 2 clks and rises 1 clk after each output change.
